// File: rtl/vdp_bus_initiator.sv
// Host-side initiator for the VDP CPU port (mode / csw_n / csr_n / cd).
// Turns a command (single port access, register write, VRAM address set)
// into one or two byte accesses, each with programmable setup, strobe and
// recovery widths so every edge survives the VDP's filtered front end.
//
// Handshake: a command transfers on a rising clk_w edge where
// cmd_valid & cmd_ready are both 1. cmd_ready is registered and is only
// high while the initiator is idle; the command fields are captured at that
// edge, so the host may change or drop them afterwards. rsp_valid and err
// are single-cycle pulses with no back-pressure.
module vdp_bus_initiator #(
  parameter int SETUP_CYCLES    = 2,
  parameter int STROBE_CYCLES   = 8,
  parameter int RECOVERY_CYCLES = 16
) (
  input  logic        clk_w,
  input  logic        reset_n_w,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [1:0]  cmd_port,
  input  logic [15:0] cmd_arg,
  output logic [1:0]  mode_o,
  output logic        csw_n_o,
  output logic        csr_n_o,
  output logic [7:0]  cd_o,
  output logic        cd_oe,
  input  logic [7:0]  cd_i,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        err,
  output logic [2:0]  dbg_state_o
);

  localparam logic [2:0] OP_WRITE_PORT = 3'd0;
  localparam logic [2:0] OP_READ_PORT  = 3'd1;
  localparam logic [2:0] OP_WRITE_REG  = 3'd2;
  localparam logic [2:0] OP_SET_WADDR  = 3'd3;
  localparam logic [2:0] OP_SET_RADDR  = 3'd4;

  // One shared down-counter times SETUP, STROBE and RECOVER.
  localparam int MAX_AB     = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAX_C      = (MAX_AB > RECOVERY_CYCLES) ? MAX_AB : RECOVERY_CYCLES;
  localparam int CNT_W      = (MAX_C > 1) ? $clog2(MAX_C) : 1;
  localparam int RECOV_LOAD = (RECOVERY_CYCLES > 0) ? RECOVERY_CYCLES - 1 : 0;

  localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_STROBE = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_RECOV  = CNT_W'(RECOV_LOAD);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             byte_idx_q, byte_idx_d;
  logic [7:0]       byte0_q, byte0_d;
  logic [7:0]       byte1_q, byte1_d;
  logic             two_q, two_d;
  logic             rd_q, rd_d;
  logic [1:0]       port_q, port_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             csw_n_q, csw_n_d;
  logic             csr_n_q, csr_n_d;
  logic [1:0]       mode_q, mode_d;
  logic [7:0]       cd_q, cd_d;
  logic             cd_oe_q, cd_oe_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic             err_q, err_d;

  logic             accept;
  logic             more_bytes;
  logic             dec_legal;
  logic [1:0]       dec_port;
  logic [7:0]       dec_b0;
  logic [7:0]       dec_b1;
  logic             dec_two;
  logic             dec_rd;
  logic [7:0]       cur_byte;
  logic             unused_arg_hi;

  // Address/register bits above 13 carry no meaning on this port.
  assign unused_arg_hi = ^cmd_arg[15:14];

  assign accept     = cmd_valid & cmd_ready_q;
  assign more_bytes = two_q & ~byte_idx_q;

  // Decode the incoming command into a one- or two-byte access list.
  always_comb begin
    dec_legal = 1'b1;
    dec_port  = 2'd1;
    dec_b0    = cmd_arg[7:0];
    dec_b1    = 8'h00;
    dec_two   = 1'b0;
    dec_rd    = 1'b0;
    case (cmd_op)
      OP_WRITE_PORT: dec_port = cmd_port;
      OP_READ_PORT: begin
        dec_port = cmd_port;
        dec_rd   = 1'b1;
        dec_b0   = 8'h00;
      end
      OP_WRITE_REG: begin
        dec_b1  = {2'b10, cmd_arg[13:8]};
        dec_two = 1'b1;
      end
      OP_SET_WADDR: begin
        dec_b1  = {2'b01, cmd_arg[13:8]};
        dec_two = 1'b1;
      end
      OP_SET_RADDR: begin
        dec_b1  = {2'b00, cmd_arg[13:8]};
        dec_two = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // State register: every flop, async active-low reset to the idle bus.
  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      byte_idx_q  <= 1'b0;
      byte0_q     <= 8'h00;
      byte1_q     <= 8'h00;
      two_q       <= 1'b0;
      rd_q        <= 1'b0;
      port_q      <= 2'd0;
      cmd_ready_q <= 1'b0;
      csw_n_q     <= 1'b1;
      csr_n_q     <= 1'b1;
      mode_q      <= 2'd0;
      cd_q        <= 8'h00;
      cd_oe_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      byte_idx_q  <= byte_idx_d;
      byte0_q     <= byte0_d;
      byte1_q     <= byte1_d;
      two_q       <= two_d;
      rd_q        <= rd_d;
      port_q      <= port_d;
      cmd_ready_q <= cmd_ready_d;
      csw_n_q     <= csw_n_d;
      csr_n_q     <= csr_n_d;
      mode_q      <= mode_d;
      cd_q        <= cd_d;
      cd_oe_q     <= cd_oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic: phase sequencing, command capture and read capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    byte_idx_d  = byte_idx_q;
    byte0_d     = byte0_q;
    byte1_d     = byte1_q;
    two_d       = two_q;
    rd_d        = rd_q;
    port_d      = port_q;
    err_d       = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (dec_legal) begin
            state_d    = ST_SETUP;
            cnt_d      = LD_SETUP;
            byte_idx_d = 1'b0;
            byte0_d    = dec_b0;
            byte1_d    = dec_b1;
            two_d      = dec_two;
            rd_d       = dec_rd;
            port_d     = dec_port;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = LD_STROBE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          // Sample the bus on the last strobe-low cycle; visible in HOLD.
          if (rd_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = cd_i;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (RECOVERY_CYCLES > 0) begin
          state_d = ST_RECOVER;
          cnt_d   = LD_RECOV;
        end else if (more_bytes) begin
          state_d    = ST_SETUP;
          cnt_d      = LD_SETUP;
          byte_idx_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RECOVER: begin
        if (cnt_q == '0) begin
          if (more_bytes) begin
            state_d    = ST_SETUP;
            cnt_d      = LD_SETUP;
            byte_idx_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: bus pins for the coming cycle, registered so they never glitch.
  always_comb begin
    cur_byte    = byte_idx_d ? byte1_d : byte0_d;
    cmd_ready_d = (state_d == ST_IDLE);
    mode_d      = mode_q;
    cd_d        = cd_q;
    cd_oe_d     = 1'b0;
    csw_n_d     = 1'b1;
    csr_n_d     = 1'b1;
    case (state_d)
      ST_SETUP: begin
        mode_d  = port_d;
        cd_d    = cur_byte;
        cd_oe_d = ~rd_d;
      end
      ST_STROBE: begin
        cd_oe_d = ~rd_d;
        // Exactly one strobe can be low: selected by the read flag.
        csw_n_d = rd_d;
        csr_n_d = ~rd_d;
      end
      ST_HOLD: cd_oe_d = ~rd_d;
      default: ;
    endcase
  end

  assign cmd_ready   = cmd_ready_q;
  assign mode_o      = mode_q;
  assign csw_n_o     = csw_n_q;
  assign csr_n_o     = csr_n_q;
  assign cd_o        = cd_q;
  assign cd_oe       = cd_oe_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_vdp_bus_initiator.sv
// Bench for vdp_bus_initiator: a default-parameter instance (a) and a
// minimal-timing instance (b, S=1 T=2 R=0) receive the same command table;
// hand-written sequences cover held cmd_valid and reset during a strobe.
module tb_vdp_bus_initiator;

  localparam int S_A = 2, T_A = 8, R_A = 16;
  localparam int S_B = 1, T_B = 2, R_B = 0;
  localparam int N_A = S_A + T_A + 1 + R_A;
  localparam int N_B = S_B + T_B + 1 + R_B;
  localparam int MON_CYC = 2 * N_A + 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT wiring ----------------
  logic [1:0]       cmd_valid_w = 2'b00;
  logic [2:0]       cmd_op = 3'd0;
  logic [1:0]       cmd_port = 2'd0;
  logic [15:0]      cmd_arg = 16'h0000;
  logic [1:0]       cmd_ready_w, csw_w, csr_w, cd_oe_w, rsp_valid_w, err_w;
  logic [1:0][1:0]  mode_w;
  logic [1:0][7:0]  cd_o_w, rsp_data_w;
  logic [1:0][7:0]  cd_i_w = '0;
  logic [1:0][2:0]  dbg_w;

  vdp_bus_initiator #(.SETUP_CYCLES(S_A), .STROBE_CYCLES(T_A), .RECOVERY_CYCLES(R_A)) u_dut_a (
    .clk_w(clk), .reset_n_w(reset_n), .cmd_valid(cmd_valid_w[0]), .cmd_ready(cmd_ready_w[0]),
    .cmd_op(cmd_op), .cmd_port(cmd_port), .cmd_arg(cmd_arg), .mode_o(mode_w[0]),
    .csw_n_o(csw_w[0]), .csr_n_o(csr_w[0]), .cd_o(cd_o_w[0]), .cd_oe(cd_oe_w[0]),
    .cd_i(cd_i_w[0]), .rsp_valid(rsp_valid_w[0]), .rsp_data(rsp_data_w[0]), .err(err_w[0]),
    .dbg_state_o(dbg_w[0])
  );

  vdp_bus_initiator #(.SETUP_CYCLES(S_B), .STROBE_CYCLES(T_B), .RECOVERY_CYCLES(R_B)) u_dut_b (
    .clk_w(clk), .reset_n_w(reset_n), .cmd_valid(cmd_valid_w[1]), .cmd_ready(cmd_ready_w[1]),
    .cmd_op(cmd_op), .cmd_port(cmd_port), .cmd_arg(cmd_arg), .mode_o(mode_w[1]),
    .csw_n_o(csw_w[1]), .csr_n_o(csr_w[1]), .cd_o(cd_o_w[1]), .cd_oe(cd_oe_w[1]),
    .cd_i(cd_i_w[1]), .rsp_valid(rsp_valid_w[1]), .rsp_data(rsp_data_w[1]), .err(err_w[1]),
    .dbg_state_o(dbg_w[1])
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]  op;
    logic [1:0]  port;
    logic [15:0] arg;
    logic [7:0]  rd_val;
    int          nbytes;
    logic [1:0]  mode;
    logic [7:0]  b0;
    logic [7:0]  b1;
    bit          is_read;
    bit          is_err;
    string       name;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] op, input logic [1:0] port, input logic [15:0] arg,
                              input logic [7:0] rd_val, input int nbytes, input logic [1:0] mode,
                              input logic [7:0] b0, input logic [7:0] b1, input bit is_read,
                              input bit is_err, input string name);
    vec_t v;
    v.op = op; v.port = port; v.arg = arg; v.rd_val = rd_val; v.nbytes = nbytes;
    v.mode = mode; v.b0 = b0; v.b1 = b1; v.is_read = is_read; v.is_err = is_err; v.name = name;
    return v;
  endfunction

  // ---------------- bus monitor state ----------------
  int fall_cyc[2][2];
  int width[2][2];
  int mode_s[2][2];
  int byte_s[2][2];
  int oe_s[2][2];
  int nfall[2];
  int both_low[2];
  int stable_bad[2];
  int setup_bad[2];
  int nrsp[2];
  int rsp_cyc[2];
  int rsp_dat[2];
  int ready_cyc[2];
  int nerr[2];
  int err_cyc[2];
  int oe_idle_bad[2];

  // Watch both DUTs for ncyc cycles after the acceptance edge (cycle 1 is
  // the first cycle after that edge). cd_i carries rd_val only while the
  // read strobe is low, so a mistimed capture sees the complement.
  task automatic monitor(input int ncyc, input logic [7:0] rd_val);
    logic       prev_low[2];
    logic [1:0] pm[2];
    logic [7:0] pc[2];
    logic       po[2];
    logic       low;
    for (int d = 0; d < 2; d++) begin
      nfall[d] = 0; both_low[d] = 0; stable_bad[d] = 0; setup_bad[d] = 0;
      nrsp[d] = 0; rsp_cyc[d] = -1; rsp_dat[d] = -1; ready_cyc[d] = -1;
      nerr[d] = 0; err_cyc[d] = -1; oe_idle_bad[d] = 0;
      for (int i = 0; i < 2; i++) begin
        fall_cyc[d][i] = -1; width[d][i] = -1; mode_s[d][i] = -1; byte_s[d][i] = -1; oe_s[d][i] = -1;
      end
      prev_low[d] = ~csw_w[d] | ~csr_w[d];
      pm[d] = mode_w[d]; pc[d] = cd_o_w[d]; po[d] = cd_oe_w[d];
    end
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (c == 1) begin
        cmd_valid_w = 2'b00;
        cmd_op = 3'd5;
        cmd_port = ~cmd_port;
        cmd_arg = ~cmd_arg;
      end
      for (int d = 0; d < 2; d++) begin
        low = ~csw_w[d] | ~csr_w[d];
        if (~csw_w[d] & ~csr_w[d]) both_low[d]++;
        if (low && !prev_low[d]) begin
          if (nfall[d] < 2) begin
            fall_cyc[d][nfall[d]] = c;
            mode_s[d][nfall[d]] = int'(mode_w[d]);
            byte_s[d][nfall[d]] = int'(cd_o_w[d]);
            oe_s[d][nfall[d]] = int'(cd_oe_w[d]);
          end
          if (pm[d] != mode_w[d] || pc[d] != cd_o_w[d] || po[d] != cd_oe_w[d]) setup_bad[d]++;
          nfall[d]++;
        end
        if (low && prev_low[d] && (pm[d] != mode_w[d] || pc[d] != cd_o_w[d] || po[d] != cd_oe_w[d]))
          stable_bad[d]++;
        if (!low && prev_low[d] && nfall[d] >= 1 && nfall[d] <= 2)
          width[d][nfall[d]-1] = c - fall_cyc[d][nfall[d]-1];
        if (rsp_valid_w[d]) begin nrsp[d]++; rsp_cyc[d] = c; rsp_dat[d] = int'(rsp_data_w[d]); end
        if (err_w[d]) begin nerr[d]++; err_cyc[d] = c; end
        if (cmd_ready_w[d] && ready_cyc[d] < 0) ready_cyc[d] = c;
        if (cmd_ready_w[d] && cd_oe_w[d]) oe_idle_bad[d]++;
        cd_i_w[d] = ~csr_w[d] ? rd_val : ~rd_val;
        prev_low[d] = low;
        pm[d] = mode_w[d]; pc[d] = cd_o_w[d]; po[d] = cd_oe_w[d];
      end
    end
  endtask

  task automatic wait_idle(input logic [1:0] mask);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (((cmd_ready_w & mask) != mask) && k < 200);
    if ((cmd_ready_w & mask) != mask) chk("idle_wait_timeout", int'(cmd_ready_w & mask), int'(mask));
  endtask

  // Apply one table entry to both DUTs and compare against the timing model.
  task automatic run_vec(input vec_t v);
    int s, t, r, n, nb;
    wait_idle(2'b11);
    cmd_op = v.op; cmd_port = v.port; cmd_arg = v.arg;
    cd_i_w[0] = ~v.rd_val; cd_i_w[1] = ~v.rd_val;
    cmd_valid_w = 2'b11;
    monitor(MON_CYC, v.rd_val);
    for (int d = 0; d < 2; d++) begin
      s = d ? S_B : S_A; t = d ? T_B : T_A; r = d ? R_B : R_A;
      n = s + t + 1 + r;
      nb = v.is_err ? 0 : v.nbytes;
      chk($sformatf("%s/d%0d/strobe_count", v.name, d), nfall[d], nb);
      for (int i = 0; i < nb; i++) begin
        chk($sformatf("%s/d%0d/fall_cycle%0d", v.name, d, i), fall_cyc[d][i], s + 1 + i * n);
        chk($sformatf("%s/d%0d/width%0d", v.name, d, i), width[d][i], t);
        chk($sformatf("%s/d%0d/mode%0d", v.name, d, i), mode_s[d][i], int'(v.mode));
        chk($sformatf("%s/d%0d/cd_oe%0d", v.name, d, i), oe_s[d][i], v.is_read ? 0 : 1);
        if (!v.is_read)
          chk($sformatf("%s/d%0d/byte%0d", v.name, d, i), byte_s[d][i], int'(i ? v.b1 : v.b0));
      end
      if (nb == 2)
        chk($sformatf("%s/d%0d/pair_gap", v.name, d), fall_cyc[d][1] - (fall_cyc[d][0] + width[d][0]), 1 + r + s);
      chk($sformatf("%s/d%0d/ready_cycle", v.name, d), ready_cyc[d], (nb > 0) ? nb * n + 1 : 1);
      chk($sformatf("%s/d%0d/rsp_count", v.name, d), nrsp[d], v.is_read ? 1 : 0);
      if (v.is_read) begin
        chk($sformatf("%s/d%0d/rsp_cycle", v.name, d), rsp_cyc[d], s + t + 1);
        chk($sformatf("%s/d%0d/rsp_data", v.name, d), rsp_dat[d], int'(v.rd_val));
      end
      chk($sformatf("%s/d%0d/err_count", v.name, d), nerr[d], v.is_err ? 1 : 0);
      if (v.is_err) chk($sformatf("%s/d%0d/err_cycle", v.name, d), err_cyc[d], 1);
      chk($sformatf("%s/d%0d/both_low", v.name, d), both_low[d], 0);
      chk($sformatf("%s/d%0d/strobe_stable", v.name, d), stable_bad[d], 0);
      chk($sformatf("%s/d%0d/setup_stable", v.name, d), setup_bad[d], 0);
      chk($sformatf("%s/d%0d/oe_idle", v.name, d), oe_idle_bad[d], 0);
    end
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[12];

  initial begin
    int  h2_falls;
    int  h2_cyc[2];
    int  h2_byte[2];
    logic h2_prev;

    vecs[0]  = mk(3'd0, 2'd0, 16'h005A, 8'h99, 1, 2'd0, 8'h5A, 8'h00, 1'b0, 1'b0, "wr_port0");
    vecs[1]  = mk(3'd1, 2'd1, 16'h0000, 8'hC3, 1, 2'd1, 8'h00, 8'h00, 1'b1, 1'b0, "rd_port1");
    vecs[2]  = mk(3'd2, 2'd0, 16'h07F4, 8'h99, 2, 2'd1, 8'hF4, 8'h87, 1'b0, 1'b0, "wr_reg7");
    vecs[3]  = mk(3'd3, 2'd0, 16'h3FFF, 8'h99, 2, 2'd1, 8'hFF, 8'h7F, 1'b0, 1'b0, "set_waddr_3fff");
    vecs[4]  = mk(3'd4, 2'd3, 16'h1234, 8'h99, 2, 2'd1, 8'h34, 8'h12, 1'b0, 1'b0, "set_raddr_1234");
    vecs[5]  = mk(3'd0, 2'd3, 16'hFFA5, 8'h99, 1, 2'd3, 8'hA5, 8'h00, 1'b0, 1'b0, "wr_port3");
    vecs[6]  = mk(3'd1, 2'd2, 16'hABCD, 8'h3C, 1, 2'd2, 8'h00, 8'h00, 1'b1, 1'b0, "rd_port2");
    vecs[7]  = mk(3'd6, 2'd1, 16'h1234, 8'h99, 0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, "illegal6");
    vecs[8]  = mk(3'd2, 2'd2, 16'hFF00, 8'h99, 2, 2'd1, 8'h00, 8'hBF, 1'b0, 1'b0, "wr_reg3f");
    vecs[9]  = mk(3'd7, 2'd0, 16'h0000, 8'h99, 0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, "illegal7");
    vecs[10] = mk(3'd1, 2'd0, 16'h0000, 8'hA5, 1, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, "rd_port0");
    vecs[11] = mk(3'd3, 2'd1, 16'h0000, 8'h99, 2, 2'd1, 8'h00, 8'h40, 1'b0, 1'b0, "set_waddr_0000");

    // Reset state, held for a few clocks.
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst/d%0d/cmd_ready", d), int'(cmd_ready_w[d]), 0);
      chk($sformatf("rst/d%0d/csw_n", d), int'(csw_w[d]), 1);
      chk($sformatf("rst/d%0d/csr_n", d), int'(csr_w[d]), 1);
      chk($sformatf("rst/d%0d/mode", d), int'(mode_w[d]), 0);
      chk($sformatf("rst/d%0d/cd_o", d), int'(cd_o_w[d]), 0);
      chk($sformatf("rst/d%0d/cd_oe", d), int'(cd_oe_w[d]), 0);
      chk($sformatf("rst/d%0d/rsp_valid", d), int'(rsp_valid_w[d]), 0);
      chk($sformatf("rst/d%0d/rsp_data", d), int'(rsp_data_w[d]), 0);
      chk($sformatf("rst/d%0d/err", d), int'(err_w[d]), 0);
      chk($sformatf("rst/d%0d/state", d), int'(dbg_w[d]), 0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_rel/d%0d/cmd_ready", d), int'(cmd_ready_w[d]), 1);
      chk($sformatf("rst_rel/d%0d/strobes", d), int'({csw_w[d], csr_w[d]}), 3);
      chk($sformatf("rst_rel/d%0d/cd_oe", d), int'(cd_oe_w[d]), 0);
    end

    // Table-driven commands.
    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Held cmd_valid across two commands (instance a only); the argument
    // changes right after the first acceptance to show it was latched.
    wait_idle(2'b01);
    cmd_op = 3'd0; cmd_port = 2'd2; cmd_arg = 16'h0011;
    cmd_valid_w = 2'b01;
    h2_falls = 0; h2_cyc[0] = -1; h2_cyc[1] = -1; h2_byte[0] = -1; h2_byte[1] = -1;
    h2_prev = ~csw_w[0];
    for (int c = 1; c <= 62; c++) begin
      @(negedge clk);
      if (c == 1) cmd_arg = 16'h0022;
      if (c == 30) cmd_valid_w = 2'b00;
      if (~csw_w[0] && !h2_prev) begin
        if (h2_falls < 2) begin h2_cyc[h2_falls] = c; h2_byte[h2_falls] = int'(cd_o_w[0]); end
        h2_falls++;
      end
      h2_prev = ~csw_w[0];
    end
    chk("held_valid/strobe_count", h2_falls, 2);
    chk("held_valid/fall0", h2_cyc[0], S_A + 1);
    chk("held_valid/fall1", h2_cyc[1], N_A + 1 + S_A + 1);
    chk("held_valid/byte0", h2_byte[0], 8'h11);
    chk("held_valid/byte1", h2_byte[1], 8'h22);
    chk("held_valid/ready_end", int'(cmd_ready_w[0]), 1);

    // Reset asserted mid-strobe of SET_RADDR (instance a).
    wait_idle(2'b11);
    cmd_op = 3'd4; cmd_port = 2'd0; cmd_arg = 16'h2A55;
    cmd_valid_w = 2'b01;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) cmd_valid_w = 2'b00;
    end
    chk("rst_mid/csw_low_before", int'(csw_w[0]), 0);
    chk("rst_mid/cd_oe_before", int'(cd_oe_w[0]), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid/csw_async_high", int'(csw_w[0]), 1);
    chk("rst_mid/csr_async_high", int'(csr_w[0]), 1);
    chk("rst_mid/cd_oe_async_low", int'(cd_oe_w[0]), 0);
    repeat (2) @(negedge clk);
    chk("rst_mid/ready_in_reset", int'(cmd_ready_w[0]), 0);
    reset_n = 1'b1;
    monitor(MON_CYC, 8'h00);
    chk("rst_mid/no_second_byte", nfall[0], 0);
    chk("rst_mid/no_rsp", nrsp[0], 0);
    chk("rst_mid/ready_after", ready_cyc[0], 1);
    chk("rst_mid/cd_oe_idle", oe_idle_bad[0], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
